// File: rtl/sprite_fetch_arbiter.sv
//==============================================================================
// Module   : sprite_fetch_arbiter
// Desc     : Shares one single-read-port sprite ROM between NUM_REQ pixel
//            sources. Registered round-robin grant (one ROM read per cycle),
//            fixed-latency responses routed back by a tag shift register, and
//            a line-synchronous FLUSH that drains the pipe and restarts the
//            round-robin from requester 0.
// Options  : FETCH_STATS_EN - adds overrun_count_o, a saturating 16-bit count
//            of LineStart pulses that found a request still waiting.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sprite_fetch_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 6,
    parameter int ROM_LAT = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      line_start_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      rom_rd_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_data_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]               overrun_count_o
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // After reset / FLUSH the search starts at (NUM_REQ-1)+1 = requester 0.
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);
    // FLUSH counts down from ROM_LAT-1 to 0, giving exactly ROM_LAT cycles.
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ROM_LAT - 1);

    // FSM state
    logic [1:0]                    state_q, state_d;
    logic [CNT_W-1:0]              flush_cnt_q, flush_cnt_d;

    // Grant / ROM request registers
    logic [IDX_W-1:0]              last_q, last_d;
    logic [NUM_REQ-1:0]            ack_q, ack_d;
    logic                          rd_q, rd_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;

    // Response tag pipe: stage k holds the read issued k+1 cycles ago
    logic [ROM_LAT-1:0]            tag_vld_q;
    logic [ROM_LAT-1:0][IDX_W-1:0] tag_idx_q;

    // Combinational helpers
    logic [NUM_REQ-1:0]            req_masked;
    logic                          win_found;
    logic [IDX_W-1:0]              win_idx;
    logic [IDX_W-1:0]              cand;
    logic                          any_req;
    logic                          pipe_busy;
    logic                          grant;

    assign any_req   = |req_i;
    // A read is in flight from the cycle RomRd is high until its response cycle.
    assign pipe_busy = rd_q | (|tag_vld_q);

    // Round-robin search from last_q+1 with wrap; the requester being acked
    // this cycle is masked since its Req has not dropped yet.
    always_comb begin
        req_masked = req_i & ~ack_q;
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && req_masked[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // FSM next state: LineStart overrides everything and (re)starts FLUSH
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (line_start_i) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LAST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_d = ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (!any_req && !pipe_busy) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_d = any_req ? ST_ARB : ST_IDLE;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: grant only in ARB and never in a LineStart cycle
    always_comb begin
        grant  = (state_q == ST_ARB) && !line_start_i && win_found;
        ack_d  = grant ? (NUM_REQ'(1) << win_idx) : '0;
        rd_d   = grant;
        addr_d = grant ? req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W] : addr_q;
        if (line_start_i) begin
            last_d = LAST_RST;
        end else if (grant) begin
            last_d = win_idx;
        end else begin
            last_d = last_q;
        end
    end

    // Registered grant, ROM strobe/address and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= LAST_RST;
            ack_q  <= '0;
            rd_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            last_q <= last_d;
            ack_q  <= ack_d;
            rd_q   <= rd_d;
            addr_q <= addr_d;
        end
    end

    // Tag shift register; last_q equals the granted index throughout the
    // cycle rd_q is high, so it serves as the tag. Tags survive LineStart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_vld_q <= '0;
            tag_idx_q <= '0;
        end else begin
            tag_vld_q[0] <= rd_q;
            tag_idx_q[0] <= last_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    assign ack_o       = ack_q;
    assign rom_rd_o    = rd_q;
    assign rom_addr_o  = addr_q;
    assign rsp_valid_o = tag_vld_q[ROM_LAT-1] ? (NUM_REQ'(1) << tag_idx_q[ROM_LAT-1]) : '0;
    assign rsp_data_o  = rom_data_i;

`ifdef FETCH_STATS_EN
    logic [15:0] overrun_q, overrun_d;

    // Count LineStarts that catch a request not being acked, saturating
    always_comb begin
        overrun_d = overrun_q;
        if (line_start_i && (|(req_i & ~ack_q)) && (overrun_q != 16'hFFFF)) begin
            overrun_d = overrun_q + 16'd1;
        end
    end

    // Overrun counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_count_o = overrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sprite_fetch_arbiter.sv
//==============================================================================
// Module   : tb_sprite_fetch_arbiter
// Desc     : Self-checking bench for sprite_fetch_arbiter. A transaction-level
//            model (queues of outstanding reads) predicts every output each
//            cycle; directed scenarios add hand-computed literal expectations.
// Options  : FETCH_STATS_EN - also checks overrun_count_o.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_fetch_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 6;
    localparam int L  = 2;
    localparam logic [DW-1:0] ROM_XOR = 6'h15;
    localparam int S_IDLE = 0, S_ARB = 1, S_FLUSH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ls = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = {16'h7804, 16'h5603, 16'h3402, 16'h1201};
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    ack;
    logic            rom_rd;
    logic [AW-1:0]   rom_addr;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
`ifdef FETCH_STATS_EN
    logic [15:0]     ovr;
`endif

    sprite_fetch_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (L)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .line_start_i (ls),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .ack_o        (ack),
        .rom_rd_o     (rom_rd),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data)
`ifdef FETCH_STATS_EN
        ,
        .overrun_count_o (ovr)
`endif
    );

    always #5 clk = ~clk;

    // ROM with L cycles of latency; data is a fixed function of the address
    logic [AW-1:0] rom_pipe [L];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr;
        for (int k = 1; k < L; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_data = rom_pipe[L-1][DW-1:0] ^ ROM_XOR;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    int            cyc = 0;
    int            m_state, m_left, m_last, m_gnt, m_ovr;
    logic [N-1:0]  m_ack, m_rsp;
    logic          m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rsp_data;
    int            due_q[$];
    int            gid_q[$];
    logic [DW-1:0] dat_q[$];

    task automatic model_reset();
        m_state = S_IDLE; m_left = 0; m_last = N - 1; m_gnt = 0; m_ovr = 0;
        m_ack = '0; m_rd = 1'b0; m_addr = '0; m_rsp = '0; m_rsp_data = '0;
        due_q.delete(); gid_q.delete(); dat_q.delete();
    endtask

    // Advance the model across the coming rising edge using current inputs
    task automatic model_advance();
        logic [N-1:0] masked;
        bit           inflight;
        int           g;
        masked   = req & ~m_ack;
        inflight = m_rd || (due_q.size() != 0);
        if (m_rd) begin
            due_q.push_back(cyc + L);
            gid_q.push_back(m_gnt);
            dat_q.push_back(m_addr[DW-1:0] ^ ROM_XOR);
        end
        if (ls && (masked != 0) && (m_ovr < 65535)) m_ovr++;
        m_ack = '0;
        m_rd  = 1'b0;
        if (ls) begin
            m_state = S_FLUSH; m_left = L; m_last = N - 1;
        end else if (m_state == S_IDLE) begin
            if (req != 0) m_state = S_ARB;
        end else if (m_state == S_ARB) begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && masked[(m_last + k) % N]) g = (m_last + k) % N;
            if (g >= 0) begin
                m_ack[g] = 1'b1; m_rd = 1'b1; m_addr = req_addr[g*AW +: AW];
                m_last = g; m_gnt = g;
            end
            if (req == 0 && !inflight) m_state = S_IDLE;
        end else begin
            m_left--;
            if (m_left == 0) m_state = (req != 0) ? S_ARB : S_IDLE;
        end
        cyc++;
        while (due_q.size() != 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front()); void'(gid_q.pop_front()); void'(dat_q.pop_front());
        end
        m_rsp = '0;
        if (due_q.size() != 0 && due_q[0] == cyc) begin
            m_rsp[gid_q[0]] = 1'b1;
            m_rsp_data      = dat_q[0];
        end
    endtask

    // Compare every cycle on the falling edge, then step the model
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("ack", ack, m_ack);
            chk("rom_rd", rom_rd, m_rd);
            chk("rom_addr", rom_addr, m_addr);
            chk("rsp_valid", rsp_valid, m_rsp);
            if (m_rsp != 0) chk("rsp_data", rsp_data, m_rsp_data);
`ifdef FETCH_STATS_EN
            chk("overrun", ovr, m_ovr);
`endif
            if (rst_n) model_advance();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [N-1:0] r, input logic l);
        req = r;
        ls  = l;
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] s2_order [5];
    logic [7:0]   s3v;
    logic [N-1:0] s5_exp [6];

    initial begin
        s2_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        s5_exp   = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

        // Power-on reset
        repeat (3) step(4'b0000, 1'b0);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_rd", rom_rd, 1'b0);
        chk("rst_addr", rom_addr, 16'h0000);
        chk("rst_rsp", rsp_valid, 4'b0000);
        rst_n = 1'b1;

        // All four requesting: rotation from requester 0
        step(4'b1111, 1'b0);
        chk("s2_first", ack, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b0);
            chk("s2_ack", ack, s2_order[k]);
            if (k >= 2) chk("s2_rsp", rsp_valid, s2_order[k-2]);
        end
        step(4'b0000, 1'b0);
        chk("s2_rsp3", rsp_valid, 4'b1000);
        step(4'b0000, 1'b0);
        chk("s2_rsp4", rsp_valid, 4'b0001);
        repeat (6) step(4'b0000, 1'b0);

        // Single requester held: grant every other cycle
        s3v = '0;
        for (int k = 0; k < 8; k++) begin
            step(4'b0001, 1'b0);
            s3v[k] = ack[0];
        end
        chk("s3_pattern", s3v, 8'b10101010);
        repeat (6) step(4'b0000, 1'b0);

        // Reset one cycle after a read is issued: response is discarded
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        chk("s1_ack", ack, 4'b0001);
        chk("s1_addr", rom_addr, 16'h1201);
        step(4'b0000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("s1_ack0", ack, 4'b0000);
        chk("s1_rd0", rom_rd, 1'b0);
        chk("s1_addr0", rom_addr, 16'h0000);
        chk("s1_rsp0", rsp_valid, 4'b0000);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 1'b0);
            chk("s1_norsp", rsp_valid, 4'b0000);
        end

`ifdef FETCH_STATS_EN
        // Requester 3 starved across three LineStarts
        chk("s6_zero", ovr, 16'd0);
        repeat (3) step(4'b1000, 1'b1);
        chk("s6_count", ovr, 16'd3);
        repeat (3) step(4'b1000, 1'b0);
        repeat (6) step(4'b0000, 1'b0);
`endif

        // Grant to 2, LineStart the next cycle: response survives, 1 wins after FLUSH
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        chk("s4_ack2", ack, 4'b0100);
        step(4'b0100, 1'b0);
        chk("s4_ack_a1", ack, 4'b0000);
        step(4'b0110, 1'b1);
        chk("s4_rsp2", rsp_valid, 4'b0100);
        chk("s4_ack_f1", ack, 4'b0000);
        step(4'b0110, 1'b0);
        chk("s4_ack_f2", ack, 4'b0000);
        step(4'b0110, 1'b0);
        chk("s4_ack_arb", ack, 4'b0000);
        step(4'b0110, 1'b0);
        chk("s4_ack1", ack, 4'b0010);
        step(4'b0110, 1'b0);
        chk("s4_ack2b", ack, 4'b0100);
        repeat (6) step(4'b0000, 1'b0);

        // LineStart again in the second FLUSH cycle restarts the count
        for (int k = 0; k < 6; k++) begin
            step(4'b0001, (k == 0 || k == 2));
            chk("s5_ack", ack, s5_exp[k]);
        end
        repeat (6) step(4'b0000, 1'b0);

        // Mixed traffic checked by the model alone
        for (int k = 0; k < 150; k++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 11) == 0));
        repeat (6) step(4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
